z80_bus_target: RTL and testbench
=================================

Z80_BUS_TARGET -- requirements
Module: z80_bus_target

Interface
REQ-001 Parameter MEM_WAIT, default 0: extra wait cycles after backend ack for memory accesses (0..15).
REQ-002 Parameter IO_WAIT, default 1: extra wait cycles after backend ack for I/O and interrupt-acknowledge cycles (0..15).
REQ-003 clk  in  1  system clock; all state changes on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n  in  1 each  Z80 bus strobes from the CPU, active-low.
REQ-006 A  in  16  CPU address bus.
REQ-007 cpu_dout  in  8  CPU write data.
REQ-008 cpu_di  out  8  read data, or interrupt vector, returned to the CPU.
REQ-009 wait_n  out  1  wait request to the CPU, active-low.
REQ-010 int_n  out  1  maskable interrupt request to the CPU, active-low.
REQ-011 req  out  1  backend request, level, held until ack.
REQ-012 we, is_io  out  1 each  backend write flag and I/O-space flag, valid while req=1.
REQ-013 addr  out  16  and  wdata  out  8: backend address and write data, valid while req=1.
REQ-014 ack  in  1  and  rdata  in  8: backend completion strobe (one cycle) and read data, valid with ack.
REQ-015 irq  in  1  peripheral interrupt level; vector  in  8: IM2 vector.
REQ-016 inta  out  1  one-cycle pulse on each accepted interrupt-acknowledge cycle.

Function
REQ-017 FSM states: IDLE, REQ, CNT, HOLD.
REQ-018 In IDLE, the following access classes are decoded each cycle:
- mem-read: !mreq_n & !rd_n & rfsh_n.
- mem-write: !mreq_n & !wr_n.
- io-read: !iorq_n & m1_n & !rd_n.
- io-write: !iorq_n & m1_n & !wr_n.
- inta: !iorq_n & !m1_n.
REQ-019 Refresh cycles (!rfsh_n & !mreq_n) and strobe-free cycles are ignored: no req, wait_n=1.
REQ-020 If rd_n and wr_n are both low, the access is treated as a write.
REQ-021 On a mem/io access in IDLE, the block latches addr=A, wdata=cpu_dout, we and is_io; next state is REQ with req=1 from the following cycle.
REQ-022 In REQ, req stays 1 and all backend outputs stay stable until ack=1.
REQ-023 On ack=1: req drops in the same edge, and cpu_di is loaded with rdata (reads only; writes leave cpu_di unchanged).
REQ-024 After ack, the wait counter loads MEM_WAIT or IO_WAIT; the FSM enters CNT, or HOLD if the count is 0.
REQ-025 CNT decrements once per cycle and enters HOLD when the count reaches 1.
REQ-026 On inta in IDLE: cpu_di is loaded with vector, inta pulses for one cycle, and no backend req is issued; the FSM proceeds to CNT with IO_WAIT, or to HOLD if IO_WAIT=0.
REQ-027 wait_n is combinational:
- 0 when IDLE decodes a new access, or when the state is REQ or CNT.
- 1 otherwise.
REQ-028 HOLD keeps cpu_di stable and returns to IDLE once mreq_n and iorq_n are both high; no new access is accepted before then.
REQ-029 int_n = ~irq, registered one cycle; it is not masked during inta, and the peripheral clears irq.
REQ-030 ack received outside REQ is ignored.
REQ-031 If strobes deassert while in REQ or CNT (aborted cycle), the transaction still completes, then the FSM passes HOLD to IDLE without stalling.

Reset
REQ-032 While reset_n=0:
- State is IDLE and the wait counter is 0.
- req=0, we=0, is_io=0, inta=0, addr=0, wdata=0, cpu_di=8'hFF.
- int_n=1; wait_n follows REQ-027.
REQ-033 Reset asserted mid-transaction aborts it immediately; no ack is awaited after release.

Verification
REQ-034 Mem-read A=16'h1234, MEM_WAIT=0, ack with rdata=8'hA5 two cycles after req -> req=1 for exactly 2 cycles, wait_n=0 until the ack edge, cpu_di=8'hA5.
REQ-035 IO-write A=16'h00FE, cpu_dout=8'h3C, IO_WAIT=2, immediate ack -> we=1, is_io=1, wdata=8'h3C, wait_n low for 1+1+2 cycles.
REQ-036 irq=1, vector=8'h40, inta cycle -> int_n=0 one cycle after irq, inta pulses once, cpu_di=8'h40, req never asserts.
REQ-037 Refresh cycle (mreq_n=0, rfsh_n=0, rd_n=1) -> req=0, wait_n=1 throughout.
REQ-038 reset_n pulsed low while in REQ -> req=0 and cpu_di=8'hFF at once; a later ack produces no state change.

Source files
------------

// File: rtl/z80_bus_target.sv
// z80_bus_target
//   Z80 bus target that turns CPU memory, I/O and interrupt-acknowledge cycles
//   into single level-handshake requests on a simple backend bus. It holds the
//   CPU in wait until the backend acknowledges and the configured extra wait
//   cycles have elapsed.
//
// Parameters
//   MEM_WAIT  extra wait cycles after ack for memory accesses (0..15)
//   IO_WAIT   extra wait cycles after ack for I/O and interrupt-acknowledge (0..15)
//
// Ports
//   clk, reset_n                            clock, async active-low reset
//   m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n CPU strobes (active-low)
//   A, cpu_dout                             CPU address / write data
//   cpu_di                                  read data or IM2 vector to the CPU
//   wait_n, int_n                           CPU wait and interrupt request
//   req, we, is_io, addr, wdata             backend request and its attributes
//   ack, rdata                              backend completion strobe and read data
//   irq, vector                             peripheral interrupt level and IM2 vector
//   inta                                    one-cycle pulse per accepted INTA cycle
//
// state | meaning
// IDLE  | decoding CPU strobes, ready for a new cycle
// REQ   | backend request outstanding, waiting for ack
// CNT   | counting extra wait cycles after ack / INTA
// HOLD  | data stable, waiting for the CPU to end the bus cycle
module z80_bus_target #(
  parameter int MEM_WAIT = 0,
  parameter int IO_WAIT  = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m1_n,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        rfsh_n,
  input  logic [15:0] A,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_di,
  output logic        wait_n,
  output logic        int_n,
  output logic        req,
  output logic        we,
  output logic        is_io,
  output logic [15:0] addr,
  output logic [7:0]  wdata,
  input  logic        ack,
  input  logic [7:0]  rdata,
  input  logic        irq,
  input  logic [7:0]  vector,
  output logic        inta
);

  localparam logic [3:0] MEM_WAIT_L = 4'(MEM_WAIT);
  localparam logic [3:0] IO_WAIT_L  = 4'(IO_WAIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_CNT,
    S_HOLD
  } state_t;

  state_t      state;
  logic [3:0]  cnt;

  logic        acc_rw;
  logic        dec_mem;
  logic        dec_io;
  logic        dec_inta;
  logic        dec_any;
  logic [3:0]  ack_wait;

  // Memory strobes are qualified by rfsh_n so refresh cycles never reach the
  // backend, even if a write strobe happens to be low during refresh.
  assign acc_rw   = !rd_n || !wr_n;
  assign dec_mem  = !mreq_n && rfsh_n && acc_rw;
  assign dec_io   = !iorq_n && m1_n && acc_rw;
  assign dec_inta = !iorq_n && !m1_n;
  assign dec_any  = dec_mem || dec_io || dec_inta;

  assign ack_wait = is_io ? IO_WAIT_L : MEM_WAIT_L;

  // Wait is asserted in the very cycle the access is decoded so the CPU
  // cannot sample data before the backend has answered.
  assign wait_n = !(((state == S_IDLE) && dec_any) ||
                    (state == S_REQ) || (state == S_CNT));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      cnt    <= 4'd0;
      req    <= 1'b0;
      we     <= 1'b0;
      is_io  <= 1'b0;
      inta   <= 1'b0;
      addr   <= 16'h0000;
      wdata  <= 8'h00;
      cpu_di <= 8'hFF;
      int_n  <= 1'b1;
    end else begin
      int_n <= ~irq;
      inta  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (dec_mem || dec_io) begin
            addr  <= A;
            wdata <= cpu_dout;
            // rd_n and wr_n both low resolves to a write
            we    <= !wr_n;
            is_io <= !dec_mem;
            req   <= 1'b1;
            state <= S_REQ;
          end else if (dec_inta) begin
            cpu_di <= vector;
            inta   <= 1'b1;
            cnt    <= IO_WAIT_L;
            state  <= (IO_WAIT_L == 4'd0) ? S_HOLD : S_CNT;
          end
        end
        S_REQ: begin
          if (ack) begin
            req <= 1'b0;
            if (!we) cpu_di <= rdata;
            cnt   <= ack_wait;
            state <= (ack_wait == 4'd0) ? S_HOLD : S_CNT;
          end
        end
        S_CNT: begin
          cnt <= cnt - 4'd1;
          if (cnt <= 4'd1) state <= S_HOLD;
        end
        S_HOLD: begin
          // An aborted cycle already has both strobes high, so this exits at once.
          if (mreq_n && iorq_n) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_z80_bus_target.sv
module tb_z80_bus_target;

  localparam int TB_MEM_WAIT = 0;
  localparam int TB_IO_WAIT  = 2;
  localparam logic [5:0] IDLE_STRB = 6'b111111;

  logic        clk;
  logic        reset_n;
  logic        m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n;
  logic [15:0] A;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_di;
  logic        wait_n, int_n, req, we, is_io, inta;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        ack;
  logic [7:0]  rdata;
  logic        irq;
  logic [7:0]  vector;

  int checks = 0;
  int errors = 0;
  logic       exp_int_n;
  logic       irq_cap;
  logic [7:0] exp_cpu_di;

  z80_bus_target #(.MEM_WAIT(TB_MEM_WAIT), .IO_WAIT(TB_IO_WAIT)) dut (
    .clk(clk), .reset_n(reset_n),
    .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n),
    .A(A), .cpu_dout(cpu_dout), .cpu_di(cpu_di),
    .wait_n(wait_n), .int_n(int_n),
    .req(req), .we(we), .is_io(is_io), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata),
    .irq(irq), .vector(vector), .inta(inta)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // strobe order: m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n
  typedef struct {
    logic [5:0] strb;
    logic       exp_wait_n;
    logic       exp_req;
    logic       exp_we;
    logic       exp_io;
    logic       exp_inta;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic set_strb(input logic [5:0] s);
    {m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n} = s;
  endtask

  // Advance one clock; int_n must next show the inverse of irq at that edge.
  task automatic step();
    irq_cap = irq;
    @(posedge clk);
    #1;
    exp_int_n = ~irq_cap;
  endtask

  // cls: 0 mem-read, 1 mem-write, 2 io-read, 3 io-write, 4 inta, 5 refresh, 6 none
  task automatic run_txn(input int cls, input logic [15:0] a, input logic [7:0] d,
                         input logic [7:0] rd_v, input logic [7:0] vec, input int k,
                         input bit abort, input int irq_mode);
    bit         backend, is_wr, io_cls;
    int         w, n, exp_wcnt, exp_rcnt, exp_icnt;
    int         wcnt, rcnt, icnt;
    logic [5:0] s;
    backend = (cls <= 3);
    is_wr   = (cls == 1) || (cls == 3);
    io_cls  = (cls == 2) || (cls == 3);
    if (cls == 4 || io_cls) w = TB_IO_WAIT;
    else if (cls <= 1)      w = TB_MEM_WAIT;
    else                    w = 0;
    exp_rcnt = backend ? k + 1 : 0;
    exp_wcnt = backend ? 1 + (k + 1) + w : ((cls == 4) ? 1 + w : 0);
    exp_icnt = (cls == 4) ? 1 : 0;
    n = k + w + 5;
    case (cls)
      0:       s = {1'($urandom_range(0, 1)), 5'b01011};
      1:       s = {3'b101, 1'($urandom_range(0, 1)), 2'b01};
      2:       s = 6'b110011;
      3:       s = {3'b110, 1'($urandom_range(0, 1)), 2'b01};
      4:       s = 6'b010111;
      5:       s = 6'b101110;
      default: s = IDLE_STRB;
    endcase
    wcnt = 0; rcnt = 0; icnt = 0;
    vector = vec;
    for (int c = 0; c < n + 2; c++) begin
      if (c == 0) begin
        A = a;
        cpu_dout = d;
        set_strb(s);
      end else begin
        A = 16'($urandom);
        cpu_dout = 8'($urandom);
      end
      if (c == n || (abort && c == 1)) set_strb(IDLE_STRB);
      if (irq_mode == 1)      irq = 1'b1;
      else if (irq_mode == 2) irq = 1'b0;
      else                    irq = 1'($urandom_range(0, 1));
      rdata = 8'($urandom);
      if (backend && c == k + 1) begin
        ack = 1'b1;
        rdata = rd_v;
        if (!is_wr) exp_cpu_di = rd_v;
      end else if (backend && c >= 1 && c <= k) begin
        ack = 1'b0;
      end else begin
        ack = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      chk("int_n", int_n, exp_int_n);
      if (!wait_n) wcnt++;
      if (inta) icnt++;
      if (req) begin
        rcnt++;
        chk("addr", addr, a);
        chk("wdata", wdata, d);
        chk("we", we, is_wr);
        chk("is_io", is_io, io_cls);
      end
      step();
    end
    ack = 1'b0;
    if (cls == 4) exp_cpu_di = vec;
    chk($sformatf("req_cycles cls%0d", cls), rcnt, exp_rcnt);
    chk($sformatf("wait_cycles cls%0d", cls), wcnt, exp_wcnt);
    chk($sformatf("inta_pulses cls%0d", cls), icnt, exp_icnt);
    chk($sformatf("cpu_di cls%0d", cls), cpu_di, exp_cpu_di);
  endtask

  initial begin
    logic [15:0] a_v;
    logic [7:0]  d_v;

    tbl[0]  = '{6'b101011, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}; // mem read
    tbl[1]  = '{6'b101101, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}; // mem write
    tbl[2]  = '{6'b110011, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}; // io read
    tbl[3]  = '{6'b110101, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0}; // io write
    tbl[4]  = '{6'b010111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}; // inta
    tbl[5]  = '{6'b101110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // refresh
    tbl[6]  = '{6'b111111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // no strobes
    tbl[7]  = '{6'b101001, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}; // mem rd+wr -> write
    tbl[8]  = '{6'b001011, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}; // opcode fetch
    tbl[9]  = '{6'b101111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // mreq without rd/wr
    tbl[10] = '{6'b110111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // iorq without rd/wr
    tbl[11] = '{6'b101010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // refresh with rd low
    tbl[12] = '{6'b110001, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0}; // io rd+wr -> write

    reset_n = 1'b0;
    set_strb(IDLE_STRB);
    A = 16'h0; cpu_dout = 8'h0; ack = 1'b0; rdata = 8'h0; irq = 1'b0; vector = 8'h0;
    exp_int_n = 1'b1;
    exp_cpu_di = 8'hFF;
    step();
    step();
    @(negedge clk);
    chk("rst req", req, 1'b0);
    chk("rst we", we, 1'b0);
    chk("rst is_io", is_io, 1'b0);
    chk("rst inta", inta, 1'b0);
    chk("rst addr", addr, 16'h0000);
    chk("rst wdata", wdata, 8'h00);
    chk("rst cpu_di", cpu_di, 8'hFF);
    chk("rst int_n", int_n, 1'b1);
    chk("rst wait_n idle", wait_n, 1'b1);
    step();
    // wait_n is combinational even under reset
    irq = 1'b1;
    set_strb(6'b101011);
    @(negedge clk);
    chk("rst wait_n decode", wait_n, 1'b0);
    chk("rst req held", req, 1'b0);
    chk("rst int_n held", int_n, 1'b1);
    step();
    exp_int_n = 1'b1;
    irq = 1'b0;
    set_strb(IDLE_STRB);
    reset_n = 1'b1;
    step();

    // decode table: one access class per row, starting from IDLE
    for (int i = 0; i < 13; i++) begin
      a_v = 16'($urandom);
      d_v = 8'($urandom);
      A = a_v;
      cpu_dout = d_v;
      set_strb(tbl[i].strb);
      @(negedge clk);
      chk("int_n", int_n, exp_int_n);
      chk($sformatf("tbl%0d wait_n", i), wait_n, tbl[i].exp_wait_n);
      step();
      @(negedge clk);
      chk($sformatf("tbl%0d req", i), req, tbl[i].exp_req);
      chk($sformatf("tbl%0d inta", i), inta, tbl[i].exp_inta);
      if (tbl[i].exp_req) begin
        chk($sformatf("tbl%0d we", i), we, tbl[i].exp_we);
        chk($sformatf("tbl%0d is_io", i), is_io, tbl[i].exp_io);
        chk($sformatf("tbl%0d addr", i), addr, a_v);
        chk($sformatf("tbl%0d wdata", i), wdata, d_v);
      end
      step();
      set_strb(IDLE_STRB);
      ack = 1'b1;
      step();
      ack = 1'b0;
      repeat (5) step();
    end

    // back to a known cpu_di
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    exp_cpu_di = 8'hFF;
    step();

    // mem read, ack in the second request cycle, no extra wait
    run_txn(0, 16'h1234, 8'h00, 8'hA5, 8'h00, 1, 1'b0, 2);
    // io write with immediate ack and two extra wait cycles
    run_txn(3, 16'h00FE, 8'h3C, 8'h00, 8'h00, 0, 1'b0, 2);
    // interrupt acknowledge with irq raised
    run_txn(4, 16'h0000, 8'h00, 8'h00, 8'h40, 0, 1'b0, 1);
    irq = 1'b0;
    // refresh cycle
    run_txn(5, 16'h0055, 8'h00, 8'h00, 8'h00, 0, 1'b0, 2);
    // aborted mem read with a slow ack
    run_txn(0, 16'h4000, 8'h00, 8'h5A, 8'h00, 3, 1'b1, 2);

    // reset while a request is outstanding
    A = 16'hBEEF;
    cpu_dout = 8'h99;
    set_strb(6'b101011);
    step();
    @(negedge clk);
    chk("mid req before rst", req, 1'b1);
    #1;
    reset_n = 1'b0;
    #1;
    exp_cpu_di = 8'hFF;
    chk("mid rst req", req, 1'b0);
    chk("mid rst cpu_di", cpu_di, 8'hFF);
    chk("mid rst addr", addr, 16'h0000);
    chk("mid rst we", we, 1'b0);
    set_strb(IDLE_STRB);
    step();
    reset_n = 1'b1;
    ack = 1'b1;
    rdata = 8'h77;
    @(negedge clk);
    chk("late ack req", req, 1'b0);
    chk("late ack wait_n", wait_n, 1'b1);
    step();
    ack = 1'b0;
    @(negedge clk);
    chk("late ack cpu_di", cpu_di, 8'hFF);
    chk("late ack req after", req, 1'b0);
    step();

    // randomized transactions against the transaction-level model
    for (int t = 0; t < 60; t++) begin
      run_txn($urandom_range(0, 6), 16'($urandom), 8'($urandom), 8'($urandom),
              8'($urandom), $urandom_range(0, 3), ($urandom_range(0, 3) == 0), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
